// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// Purpose:
//   Control FSM for a UART transmitter. It sequences one frame as
//   START -> DATA (DATA_WIDTH cycles) -> optional PARITY -> STOP, and drives the
//   line-source select and serializer shift enable for the datapath. All
//   outputs are decoded from the registered state only, so no input reaches
//   an output in the same cycle.
//
// Parameters:
//   DATA_WIDTH  data bits per frame (1..16)
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous active-low reset
//   Data_Valid  in   frame request, sampled in IDLE and STOP only
//   PAR_EN      in   parity enable, latched with an accepted Data_Valid
//   mux_sel     out  [1:0] line source: 00 start, 01 data, 10 parity, 11 stop/idle
//   ser_en      out  serializer shift enable, one pulse per data bit
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse in the stop cycle of each frame
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    output logic [1:0] mux_sel,
    output logic       ser_en,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_next_bit_cnt;
    logic             r_par_en;
    logic             w_next_par_en;
    logic             w_accept;

    // A new frame is only accepted while the line is idle or in the stop bit,
    // which is what allows back-to-back frames without an idle gap.
    assign w_accept = Data_Valid && ((r_state == IDLE) || (r_state == STOP));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_par_en  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_bit_cnt <= w_next_bit_cnt;
            r_par_en  <= w_next_par_en;
        end
    end

    always_comb begin
        w_next_state   = IDLE;
        w_next_bit_cnt = '0;
        w_next_par_en  = r_par_en;

        if (w_accept) begin
            w_next_par_en = PAR_EN;
        end

        case (r_state)
            IDLE: begin
                w_next_state = w_accept ? START : IDLE;
            end
            START: begin
                w_next_state = DATA;
            end
            DATA: begin
                if (r_bit_cnt == CNT_LAST) begin
                    // Counter returns to 0 on the exit edge; it never wraps.
                    w_next_state = r_par_en ? PARITY : STOP;
                end else begin
                    w_next_state   = DATA;
                    w_next_bit_cnt = r_bit_cnt + 1'b1;
                end
            end
            PARITY: begin
                w_next_state = STOP;
            end
            STOP: begin
                w_next_state = w_accept ? START : IDLE;
            end
            default: begin
                // Unused encodings recover to IDLE.
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        mux_sel    = 2'b11;
        ser_en     = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;

        case (r_state)
            START: begin
                mux_sel = 2'b00;
                busy    = 1'b1;
            end
            DATA: begin
                mux_sel = 2'b01;
                ser_en  = 1'b1;
                busy    = 1'b1;
            end
            PARITY: begin
                mux_sel = 2'b10;
                busy    = 1'b1;
            end
            STOP: begin
                mux_sel    = 2'b11;
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: begin
                mux_sel = 2'b11;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Purpose:
//   Directed self-checking bench for uart_tx_ctrl with DATA_WIDTH=8. Inputs
//   change and outputs are sampled on the falling edge, so "cycle n" is the
//   interval following rising edge n.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    logic       CLK;
    logic       RST;
    logic       Data_Valid;
    logic       PAR_EN;
    logic [1:0] mux_sel;
    logic       ser_en;
    logic       busy;
    logic       frame_done;

    int n_chk;
    int n_err;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .mux_sel    (mux_sel),
        .ser_en     (ser_en),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " mux"},  32'(mux_sel),    32'h3);
        chk({tag, " busy"}, 32'(busy),       32'h0);
        chk({tag, " ser"},  32'(ser_en),     32'h0);
        chk({tag, " done"}, 32'(frame_done), 32'h0);
    endtask

    // Called in cycle 0 of a frame (START already visible). Walks the frame
    // cycle by cycle against the expected Moore outputs, then drives the
    // inputs for the edge that ends the stop cycle.
    task automatic frame_expect(input string tag, input bit par, input bit b2b,
                                input bit npar, input bit noise);
        int         last;
        int         pulses;
        logic [1:0] exp_mux;
        last   = 9 + (par ? 1 : 0);
        pulses = 0;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge CLK);
            if (c == 0)          exp_mux = 2'b00;
            else if (c <= 8)     exp_mux = 2'b01;
            else if (c == last)  exp_mux = 2'b11;
            else                 exp_mux = 2'b10;
            chk($sformatf("%s mux c%0d", tag, c),  32'(mux_sel),    32'(exp_mux));
            chk($sformatf("%s busy c%0d", tag, c), 32'(busy),       32'h1);
            chk($sformatf("%s ser c%0d", tag, c),  32'(ser_en),     32'((c >= 1 && c <= 8) ? 1 : 0));
            chk($sformatf("%s done c%0d", tag, c), 32'(frame_done), 32'((c == last) ? 1 : 0));
            if (ser_en === 1'b1) pulses++;
            if (c == last) begin
                Data_Valid = b2b;
                PAR_EN     = npar;
            end else if (noise && c >= 1 && c <= 8) begin
                Data_Valid = c[0];
                PAR_EN     = ~PAR_EN;
            end else begin
                Data_Valid = 1'b0;
            end
        end
        chk({tag, " ser pulses"}, 32'(pulses), 32'd8);
    endtask

    // Request a frame on the next rising edge and land in its cycle 0.
    task automatic request(input bit par);
        Data_Valid = 1'b1;
        PAR_EN     = par;
        @(negedge CLK);
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        RST        = 1'b0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        #2;
        chk_idle("reset");

        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk_idle("idle after reset");

        // Frame without parity: 10 busy cycles, idle in cycle 10.
        request(1'b0);
        frame_expect("nopar", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        chk_idle("nopar end");

        // Frame with parity: parity in cycle 9, stop in cycle 10.
        request(1'b1);
        frame_expect("par", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        chk_idle("par end");

        // Back-to-back: second request presented in the stop cycle.
        request(1'b0);
        frame_expect("b2b1", 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        frame_expect("b2b2", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        chk_idle("b2b end");

        // Data_Valid pulses and PAR_EN toggles during data cycles are ignored.
        request(1'b0);
        frame_expect("noise", 1'b0, 1'b0, 1'b0, 1'b1);
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        @(negedge CLK);
        chk_idle("noise end");

        // Reset during cycle 4 aborts the frame at once.
        request(1'b1);
        Data_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        chk(" midrst pre ser", 32'(ser_en), 32'h1);
        RST = 1'b0;
        #1;
        chk_idle("midrst async");
        @(negedge CLK);
        chk_idle("midrst held");
        RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk_idle($sformatf("midrst after c%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
